// File: rtl/regwrite_arbiter_pkg.sv
//------------------------------------------------------------------------------
// regwrite_arbiter_pkg : shared types and bus widths for the RegFile write arbiter
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif
`ifndef ZERO_REG_ADDR
`define ZERO_REG_ADDR 5'd0
`endif

package regwrite_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DRAIN = 2'd2
  } starve_state_e;

  typedef struct packed {
    logic                en;
    logic [`REG_ADDR_BUS] addr;
    logic [`DATA_BUS]     data;
  } wr_req_t;

  // Writes to the hard-wired zero register are architecturally dead.
  function automatic logic is_live_addr(input logic [`REG_ADDR_BUS] a);
    return a != `ZERO_REG_ADDR;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regwrite_buffer.sv
//------------------------------------------------------------------------------
// regwrite_buffer : in-order secondary write FIFO with per-entry live bit,
// address-match kill and per-register pending mask.  Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

module regwrite_buffer
  import regwrite_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [`REG_ADDR_BUS]  push_addr_i,
  input  logic [`DATA_BUS]      push_data_i,
  input  logic                  pop_i,
  input  logic                  kill_en_i,
  input  logic [`REG_ADDR_BUS]  kill_addr_i,
  output logic                  full_o,
  output logic                  empty_o,
  output wr_req_t               head_o,
  output logic [`REG_COUNT-1:0] pending_mask_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]          wr_ptr_q, rd_ptr_q;
  logic [`REG_ADDR_BUS] addr_q [DEPTH];
  logic [`DATA_BUS]     data_q [DEPTH];
  logic [DEPTH-1:0]     live_q;
  logic [AW-1:0]        wr_idx, rd_idx;
  logic                 push_ok, pop_ok;

  assign wr_idx  = wr_ptr_q[AW-1:0];
  assign rd_idx  = rd_ptr_q[AW-1:0];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign head_o.en   = live_q[rd_idx] & ~empty_o;
  assign head_o.addr = addr_q[rd_idx];
  assign head_o.data = data_q[rd_idx];

  // Live bits are cleared on pop, so live implies the slot is occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      live_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (kill_en_i && (addr_q[i] == kill_addr_i)) live_q[i] <= 1'b0;
      end
      if (pop_ok) begin
        live_q[rd_idx] <= 1'b0;
        rd_ptr_q       <= rd_ptr_q + 1'b1;
      end
      // A same-cycle push outranks the kill: the pushed value is the newer one.
      if (push_ok) begin
        addr_q[wr_idx] <= push_addr_i;
        data_q[wr_idx] <= push_data_i;
        live_q[wr_idx] <= 1'b1;
        wr_ptr_q       <= wr_ptr_q + 1'b1;
      end
    end
  end

  always_comb begin
    pending_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_q[i]) pending_mask_o[addr_q[i]] = 1'b1;
    end
    pending_mask_o[0] = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/regwrite_arbiter.sv
//------------------------------------------------------------------------------
// regwrite_arbiter : fixed-priority WB / buffered secondary RegFile write mux.
// Optional anti-starvation guard: STARVE_GUARD_EN.  Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif
`ifndef REG_COUNT
`define REG_COUNT 32
`endif

module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_en,
  input  logic [`REG_ADDR_BUS] wb_addr,
  input  logic [`DATA_BUS]     wb_data,
  input  logic                 sec_valid,
  output logic                 sec_ready,
  input  logic [`REG_ADDR_BUS] sec_addr,
  input  logic [`DATA_BUS]     sec_data,
  input  logic [`REG_ADDR_BUS] query_addr_1,
  input  logic [`REG_ADDR_BUS] query_addr_2,
  output logic                 pending_1,
  output logic                 pending_2,
  output logic                 stall_wb,
  output logic                 write_en,
  output logic [`REG_ADDR_BUS] write_addr,
  output logic [`DATA_BUS]     write_data
);

  logic                  wb_live, buf_full, buf_empty, pop, push;
  wr_req_t               head, wr_d, wr_q;
  logic [`REG_COUNT-1:0] pending_mask;

  assign wb_live   = wb_en & is_live_addr(wb_addr);
  assign pop       = ~wb_live & ~buf_empty;
  assign sec_ready = ~buf_full & ~rst;
  // Zero-address requests complete the handshake but never occupy a slot.
  assign push      = sec_valid & sec_ready & is_live_addr(sec_addr);

  regwrite_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk            (clk),
    .rst            (rst),
    .push_i         (push),
    .push_addr_i    (sec_addr),
    .push_data_i    (sec_data),
    .pop_i          (pop),
    .kill_en_i      (wb_live),
    .kill_addr_i    (wb_addr),
    .full_o         (buf_full),
    .empty_o        (buf_empty),
    .head_o         (head),
    .pending_mask_o (pending_mask)
  );

  assign pending_1 = ~rst & pending_mask[query_addr_1];
  assign pending_2 = ~rst & pending_mask[query_addr_2];

  always_comb begin
    wr_d = '0;
    if (wb_live)              wr_d = '{en: 1'b1, addr: wb_addr, data: wb_data};
    else if (pop && head.en)  wr_d = head;
  end

  always_ff @(posedge clk) begin
    if (rst) wr_q <= '0;
    else     wr_q <= wr_d;
  end

  assign write_en   = wr_q.en;
  assign write_addr = wr_q.addr;
  assign write_data = wr_q.data;

`ifdef STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  starve_state_e state_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             stall_q, blocked;

  assign blocked = wb_live & ~buf_empty;
  assign cnt_inc = (state_q == ST_IDLE) ? CNT_W'(1) : cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_COUNT: begin
          if (!blocked) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_inc;
            if (cnt_inc == CNT_W'(STARVE_LIMIT)) begin
              state_q <= ST_DRAIN;
              stall_q <= 1'b1;
            end else begin
              state_q <= ST_COUNT;
            end
          end
        end
        // The pipeline leaves the following cycle free, so the head drains then.
        ST_DRAIN: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign stall_wb = stall_q;
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign stall_wb = 1'b0;
`endif

endmodule

`default_nettype wire
